// File: rtl/datapath_sequencer_if.sv
// Panel-to-sequencer bundle: panel step/run/mode inputs plus the datapath write
// controls, display select and queue status driven back by the sequencer.
interface datapath_sequencer_if #(
    parameter int QDEPTH = 8
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          next;
    logic          start;
    logic [2:0]    MS;
    logic          W1;
    logic          WE;
    logic [2:0]    MS_out;
    logic [1:0]    LEDsel;
    logic          Done_out;
    logic          busy;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          err;

    modport master (
        output next, start, MS,
        input  W1, WE, MS_out, LEDsel, Done_out, busy, q_count, q_full, q_empty, err
    );

    modport slave (
        input  next, start, MS,
        output W1, WE, MS_out, LEDsel, Done_out, busy, q_count, q_full, q_empty, err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Queues ALU mode codes from the panel and, on start, loads Din then replays each
// queued code through EXEC/WB/SHOW, writing every result back into the accumulator.
module datapath_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int QDEPTH      = 8
) (
    input  logic                clk,
    input  logic                clear,
    datapath_sequencer_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, SHOW, DONE} state_t;

    state_t        state_q, state_d;
    logic          nextPrev_q, startPrev_q;
    logic [2:0]    fifo_q [QDEPTH];
    logic [PW-1:0] rdPtr_q, wrPtr_q;
    logic [CW-1:0] count_q;
    logic [HW-1:0] hold_q;
    logic          err_q;
    logic [2:0]    lastCode_q;
    logic          w1_q, we_q, done_q, busy_q;
    logic [1:0]    ledSel_q;

    logic          nedge, sedge, full, empty, push, pop, runGo;
    logic [2:0]    head;

    assign nedge = bus.next & ~nextPrev_q;
    assign sedge = bus.start & ~startPrev_q;
    assign full  = (count_q == CW'(QDEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rdPtr_q];
    assign push  = (state_q == IDLE) && nedge && !full;
    assign pop   = (state_q == SHOW) && (hold_q == '0);
    // A push landing on the same edge as start counts toward a non-empty queue.
    assign runGo = (state_q == IDLE) && sedge && (!empty || push);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (runGo) state_d = LOAD;
            LOAD:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = SHOW;
            SHOW:    if (pop) state_d = (count_q > CW'(1)) ? EXEC : DONE;
            DONE:    if (nedge || sedge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            w1_q     <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ledSel_q <= 2'd0;
        end else begin
            state_q <= state_d;
            w1_q    <= (state_d == WB);
            we_q    <= (state_d == LOAD) || (state_d == WB);
            done_q  <= (state_d == DONE);
            busy_q  <= state_d inside {LOAD, EXEC, WB, SHOW};
            case (state_d)
                IDLE:           ledSel_q <= 2'd0;
                LOAD, EXEC, WB: ledSel_q <= 2'd1;
                SHOW:           ledSel_q <= 2'd2;
                default:        ledSel_q <= 2'd3;
            endcase
            if (state_q == WB) begin
                hold_q <= HW'(HOLD_CYCLES - 1);
            end else if ((state_q == SHOW) && (hold_q != '0)) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            nextPrev_q  <= 1'b1;
            startPrev_q <= 1'b1;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            lastCode_q  <= 3'd0;
        end else begin
            nextPrev_q  <= bus.next;
            startPrev_q <= bus.start;
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end else if (pop) begin
                rdPtr_q    <= rdPtr_q + 1'b1;
                count_q    <= count_q - 1'b1;
                lastCode_q <= head;
            end
            if (runGo) begin
                err_q <= 1'b0;
            end else if ((state_q == IDLE) && nedge && full) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wrPtr_q] <= bus.MS;
        end
    end

    assign bus.MS_out   = (state_q == IDLE) ? bus.MS :
                          (state_q == DONE) ? lastCode_q : head;
    assign bus.W1       = w1_q;
    assign bus.WE       = we_q;
    assign bus.LEDsel   = ledSel_q;
    assign bus.Done_out = done_q;
    assign bus.busy     = busy_q;
    assign bus.q_count  = count_q;
    assign bus.q_full   = full;
    assign bus.q_empty  = empty;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: reset hold, basic run, overflow, wrap,
// simultaneous edges, DONE exit, busy immunity and mid-run reset abort.
module tb_datapath_sequencer;
    localparam int HOLD = 4;
    localparam int QD   = 8;

    logic clk = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;
    logic [2:0] expOps [16];
    int   nOps;
    int   weSeen;

    datapath_sequencer_if #(.QDEPTH(QD)) bus ();

    datapath_sequencer #(
        .HOLD_CYCLES(HOLD),
        .QDEPTH     (QD)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic nx, input logic st, input logic [2:0] ms);
        bus.next  = nx;
        bus.start = st;
        bus.MS    = ms;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pressNext(input logic [2:0] ms);
        applyStimulus(1'b1, 1'b0, ms);
        step(1);
        applyStimulus(1'b0, 1'b0, ms);
        step(1);
    endtask

    task automatic pushOp(input logic [2:0] ms);
        pressNext(ms);
        expOps[nOps] = ms;
        nOps++;
    endtask

    // Leaves the bench sitting in the LOAD cycle.
    task automatic startRun();
        applyStimulus(1'b0, 1'b1, 3'd0);
        step(1);
        applyStimulus(1'b0, 1'b0, 3'd0);
    endtask

    // Walks the cycle timeline of a run starting at LOAD: LOAD, then per op
    // EXEC, WB, HOLD x SHOW, then DONE at 1 + N*(2+HOLD).
    task automatic runCheck(input string tag);
        int last;
        int weCount;
        last    = 1 + nOps * (2 + HOLD);
        weCount = 0;
        for (int k = 0; k <= last; k++) begin
            int expWe, expLed, expDone, expBusy, expMs, expW1, chkW1, op, ph;
            chkW1 = 0;
            expW1 = 0;
            if (k == 0) begin
                expWe = 1; expLed = 1; expDone = 0; expBusy = 1;
                expMs = int'(expOps[0]); chkW1 = 1; expW1 = 0;
            end else if (k == last) begin
                expWe = 0; expLed = 3; expDone = 1; expBusy = 0;
                expMs = int'(expOps[nOps-1]);
            end else begin
                op = (k - 1) / (2 + HOLD);
                ph = (k - 1) % (2 + HOLD);
                expMs = int'(expOps[op]); expDone = 0; expBusy = 1;
                if (ph == 0) begin
                    expWe = 0; expLed = 1;
                end else if (ph == 1) begin
                    expWe = 1; expLed = 1; chkW1 = 1; expW1 = 1;
                end else begin
                    expWe = 0; expLed = 2;
                end
            end
            checkOutput($sformatf("%s k%0d WE", tag, k), 32'(bus.WE), expWe);
            checkOutput($sformatf("%s k%0d LEDsel", tag, k), 32'(bus.LEDsel), expLed);
            checkOutput($sformatf("%s k%0d MS_out", tag, k), 32'(bus.MS_out), expMs);
            checkOutput($sformatf("%s k%0d Done_out", tag, k), 32'(bus.Done_out), expDone);
            checkOutput($sformatf("%s k%0d busy", tag, k), 32'(bus.busy), expBusy);
            if (chkW1 != 0) begin
                checkOutput($sformatf("%s k%0d W1", tag, k), 32'(bus.W1), expW1);
            end
            if (bus.WE === 1'b1) weCount++;
            step(1);
        end
        checkOutput({tag, " we_pulses"}, weCount, nOps + 1);
        checkOutput({tag, " end q_count"}, 32'(bus.q_count), 0);
        checkOutput({tag, " end q_empty"}, 32'(bus.q_empty), 1);
        checkOutput({tag, " end Done_out"}, 32'(bus.Done_out), 1);
        nOps = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nOps  = 0;
        clear = 1'b1;
        applyStimulus(1'b1, 1'b1, 3'd5);
        step(2);
        checkOutput("reset q_count", 32'(bus.q_count), 0);
        checkOutput("reset q_empty", 32'(bus.q_empty), 1);
        checkOutput("reset q_full", 32'(bus.q_full), 0);
        checkOutput("reset WE", 32'(bus.WE), 0);
        checkOutput("reset W1", 32'(bus.W1), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset Done_out", 32'(bus.Done_out), 0);
        checkOutput("reset LEDsel", 32'(bus.LEDsel), 0);
        checkOutput("reset err", 32'(bus.err), 0);
        checkOutput("reset MS_out", 32'(bus.MS_out), 5);

        // Release with next/start still high: no edge may be seen.
        @(negedge clk);
        clear = 1'b0;
        step(2);
        checkOutput("hold q_count", 32'(bus.q_count), 0);
        checkOutput("hold busy", 32'(bus.busy), 0);
        checkOutput("hold WE", 32'(bus.WE), 0);
        checkOutput("hold MS_out", 32'(bus.MS_out), 5);
        applyStimulus(1'b0, 1'b0, 3'd0);
        step(1);
        checkOutput("hold2 busy", 32'(bus.busy), 0);

        $display("[TB] basic run");
        pushOp(3'd3);
        checkOutput("basic q_count1", 32'(bus.q_count), 1);
        pushOp(3'd5);
        checkOutput("basic q_count2", 32'(bus.q_count), 2);
        startRun();
        runCheck("basic");

        $display("[TB] DONE exit via next, then overflow");
        applyStimulus(1'b1, 1'b0, 3'd4);
        step(1);
        checkOutput("doneexit busy", 32'(bus.busy), 0);
        checkOutput("doneexit Done_out", 32'(bus.Done_out), 0);
        checkOutput("doneexit LEDsel", 32'(bus.LEDsel), 0);
        checkOutput("doneexit q_count", 32'(bus.q_count), 0);
        applyStimulus(1'b0, 1'b0, 3'd4);
        step(1);
        for (int i = 0; i < 8; i++) begin
            pushOp(3'((i + 1) % 8));
            if (i == 6) checkOutput("ovf q_full at 7", 32'(bus.q_full), 0);
        end
        checkOutput("ovf q_full at 8", 32'(bus.q_full), 1);
        checkOutput("ovf q_count at 8", 32'(bus.q_count), 8);
        checkOutput("ovf err at 8", 32'(bus.err), 0);
        pressNext(3'd6);
        checkOutput("ovf err at 9", 32'(bus.err), 1);
        checkOutput("ovf q_count at 9", 32'(bus.q_count), 8);
        checkOutput("ovf q_full at 9", 32'(bus.q_full), 1);
        startRun();
        checkOutput("ovf err cleared", 32'(bus.err), 0);
        runCheck("ovf");

        $display("[TB] DONE exit via start, then wrap run");
        applyStimulus(1'b0, 1'b1, 3'd0);
        step(1);
        checkOutput("startexit busy", 32'(bus.busy), 0);
        checkOutput("startexit q_count", 32'(bus.q_count), 0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        step(1);
        checkOutput("startexit no run", 32'(bus.busy), 0);
        pushOp(3'd6);
        pushOp(3'd2);
        pushOp(3'd7);
        checkOutput("wrap q_count", 32'(bus.q_count), 3);
        startRun();
        runCheck("wrap");

        $display("[TB] simultaneous edges");
        pressNext(3'd1);
        checkOutput("simul pre q_count", 32'(bus.q_count), 0);
        applyStimulus(1'b1, 1'b1, 3'd2);
        step(1);
        expOps[0] = 3'd2;
        nOps = 1;
        checkOutput("simul q_count", 32'(bus.q_count), 1);
        applyStimulus(1'b0, 1'b0, 3'd0);
        runCheck("simul");

        $display("[TB] busy immunity and reset abort");
        pressNext(3'd0);
        pushOp(3'd4);
        pushOp(3'd6);
        startRun();
        step(3);
        checkOutput("busy show LEDsel", 32'(bus.LEDsel), 2);
        applyStimulus(1'b1, 1'b1, 3'd7);
        step(1);
        checkOutput("busy q_count", 32'(bus.q_count), 2);
        checkOutput("busy LEDsel", 32'(bus.LEDsel), 2);
        checkOutput("busy still busy", 32'(bus.busy), 1);
        checkOutput("busy MS_out", 32'(bus.MS_out), 4);
        applyStimulus(1'b0, 1'b0, 3'd7);
        step(1);
        checkOutput("busy no restart", 32'(bus.WE), 0);
        clear = 1'b1;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort WE", 32'(bus.WE), 0);
        checkOutput("abort LEDsel", 32'(bus.LEDsel), 0);
        checkOutput("abort q_count", 32'(bus.q_count), 0);
        checkOutput("abort q_empty", 32'(bus.q_empty), 1);
        checkOutput("abort MS_out", 32'(bus.MS_out), 7);
        step(1);
        clear = 1'b0;
        weSeen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.WE !== 1'b0) weSeen++;
        end
        checkOutput("abort WE after", weSeen, 0);
        checkOutput("abort idle busy", 32'(bus.busy), 0);
        checkOutput("abort idle q_count", 32'(bus.q_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Chained-operation controller for the register/ALU datapath. It queues up to QDEPTH ALU mode-select codes entered from the front panel (MS plus a `next` press). On `start` it loads Din into the accumulator register, then applies each queued operation in order, writing every ALU result back into the accumulator. It sits between the panel inputs and the datapath's write controls and display-select logic, and it drives the display selector and done indicator.

## Interface
- HOLD_CYCLES, 4: cycles each intermediate result is held on the display; legal range 1..65535.
- QDEPTH, 8: operation queue depth; power of two, 2..16.

- clk  input  1  system clock; all state changes on its rising edge.
- clear  input  1  reset, asynchronous, active-high.
- next  input  1  panel step signal, synchronous level; the rising edge is detected internally.
- start  input  1  panel run signal, synchronous level; the rising edge is detected internally.
- MS  input  3  ALU mode code to enqueue.
- W1  output  1  datapath write-source select: 0 = Din, 1 = ALU result.
- WE  output  1  datapath accumulator write strobe.
- MS_out  output  3  mode code presented to the ALU.
- LEDsel  output  2  display source select: 0 = Din, 1 = operation code, 2 = ALU result, 3 = final.
- Done_out  output  1  run complete.
- busy  output  1  run in progress (states LOAD, EXEC, WB, SHOW).
- q_count  output  $clog2(QDEPTH)+1  current number of queued operations.
- q_full, q_empty  output  1  queue status flags.
- err  output  1  sticky overflow flag.

## Operation
- Edge detect: next_d and start_d are registered copies of the inputs. nedge = next & ~next_d; sedge = start & ~start_d.
- The queue is a circular FIFO with read/write pointers and a count. Push is allowed only in IDLE. Pop happens at the end of SHOW.
- State machine is Moore. All outputs except q_count, q_full, q_empty and err decode from the current state.
  - IDLE:
    - Outputs: W1=0, WE=0, LEDsel=0, MS_out=MS (preview).
    - nedge with queue not full: push MS.
    - nedge with queue full: no push; set err.
    - sedge with (queue non-empty OR push this cycle): go to LOAD, clear err. Otherwise sedge is ignored.
  - LOAD, 1 cycle:
    - Outputs: WE=1, W1=0, LEDsel=1, MS_out=head.
    - Next state: EXEC.
  - EXEC, 1 cycle (ALU settle):
    - Outputs: WE=0, LEDsel=1, MS_out=head.
    - Next state: WB.
  - WB, 1 cycle:
    - Outputs: WE=1, W1=1, LEDsel=1, MS_out=head.
    - Next state: SHOW; the hold counter loads HOLD_CYCLES-1.
  - SHOW:
    - Outputs: WE=0, LEDsel=2, MS_out=head.
    - The counter decrements each cycle.
    - When the counter reaches 0: pop. Go to EXEC if entries remain, else DONE.
  - DONE:
    - Outputs: Done_out=1, LEDsel=3, MS_out=last executed code.
    - Any nedge or sedge returns to IDLE. That edge is consumed: no push, no new run.
- During busy states, nedge and sedge are ignored. The queue contents and err are unchanged.
- Simultaneous nedge and sedge in IDLE: the push and the run start both take effect at the same edge, and the pushed entry is part of the run.
- Only one of push or pop can occur in any cycle, because they are confined to different states.

## Timing
- Reset values (while clear=1, asynchronous):
  - State is IDLE; queue is empty (q_count=0, q_empty=1, q_full=0).
  - err=0, W1=0, WE=0, Done_out=0, busy=0, LEDsel=0, MS_out=MS.
  - next_d=1 and start_d=1, so a level held through reset does not produce an edge.
- Reset mid-run aborts immediately and flushes the queue. No further WE pulses occur.
- Edge to effect: if nedge is seen in cycle t, q_count is updated in cycle t+1. If sedge is seen in cycle t, WE=1 (LOAD) in cycle t+1.
- Run of N operations:
  - LOAD: 1 cycle. Each operation: EXEC + WB + SHOW = 2 + HOLD_CYCLES cycles.
  - Done_out rises 1 + N·(2+HOLD_CYCLES) cycles after LOAD begins.
- Exactly N+1 WE pulses per run, each 1 cycle wide. They are never back-to-back: an EXEC cycle always separates a WE pulse from the next.
- Pointer wrap-around at QDEPTH is seamless. A full queue drains correctly.

## Test plan
- Reset hold: assert clear with next=1 and start=1, then release. Required: no push and no run, q_count=0, all outputs at their reset values.
- Basic run, HOLD_CYCLES=4: push MS=3, then MS=5, then pulse start. Required:
  - WE pulses at LOAD (W1=0) and at both WB cycles (W1=1).
  - MS_out=3 for the first op, then 5.
  - Done_out rises 13 cycles after LOAD; q_count=0.
- Overflow, QDEPTH=8: make 9 next presses. Required: q_full=1 after the 8th press; err=1 after the 9th; q_count stays 8. A subsequent start clears err and executes all 8 ops in FIFO order.
- Simultaneous edges: from an empty queue, assert next (MS=2) and start rising in the same cycle. Required: the run starts with one operation, MS_out=2.
- Busy immunity and reset abort:
  - Press next and start during SHOW. Required: q_count unchanged, no restart.
  - Assert clear mid-SHOW. Required: IDLE, queue empty, WE=0 from then on.
- DONE exit plus wrap: from DONE, press next. Required: IDLE with no push. Then push 8, run, push 3, run. Required: codes are executed in order across the pointer wrap.
